// File: rtl/vta_sim_pkg.sv
// Shared types for the tsim stall controller: FSM state encoding and counter width helper.
// No logic, no latency, no backpressure.
package vta_sim_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALT   = 2'd2,
        ST_RESUME = 2'd3
    } state_e;

    // Wide enough to hold 0..max_outstanding inclusive.
    function automatic int outst_w(input int max_outstanding);
        return $clog2(max_outstanding) + 1;
    endfunction

endpackage

// File: rtl/vta_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// One-cycle update latency; no backpressure, holds at all-ones.
module vta_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !(&cnt_q)) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/vta_sim_stall_ctrl.sv
// Freezes the accelerator on a DPI wait: blocks requests, drains bursts, drops clock enable, guarded resume.
// Request path is combinational; accel_en falls one edge after an idle wait and returns RESUME_DLY+1 edges after release.
module vta_sim_stall_ctrl
    import vta_sim_pkg::*;
#(
    parameter  int MAX_OUTSTANDING = 8,
    parameter  int CNT_W           = 32,
    parameter  int RESUME_DLY      = 2,
    localparam int OUTST_W         = outst_w(MAX_OUTSTANDING)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               dpi_wait,
    input  logic               req_valid_in,
    output logic               req_ready_in,
    output logic               req_valid_out,
    input  logic               req_ready_out,
    input  logic               rsp_valid,
    input  logic               rsp_last,
    output logic               accel_en,
    output logic               halted,
    output logic [OUTST_W-1:0] outstanding,
    input  logic               cnt_clear,
    output logic [CNT_W-1:0]   run_cycles,
    output logic [CNT_W-1:0]   stall_cycles,
    output logic               err_underflow
);

    localparam int                 TMR_W    = (RESUME_DLY > 1) ? $clog2(RESUME_DLY) : 1;
    localparam logic [OUTST_W-1:0] OUT_MAX  = OUTST_W'(MAX_OUTSTANDING);
    localparam logic [OUTST_W-1:0] OUT_ONE  = OUTST_W'(1);
    localparam logic [TMR_W-1:0]   TMR_LOAD = TMR_W'(RESUME_DLY - 1);
    localparam logic [TMR_W-1:0]   TMR_ONE  = TMR_W'(1);

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [OUTST_W-1:0] out_q, out_d;
    logic               accel_en_q, halted_q, err_q;
    logic               block, issue, rsp_end, done;

    assign block         = (state_q != ST_RUN) | (out_q == OUT_MAX);
    assign req_valid_out = req_valid_in & ~block;
    assign req_ready_in  = req_ready_out & ~block;
    assign issue         = req_valid_out & req_ready_out;
    assign rsp_end       = rsp_valid & rsp_last;
    assign done          = rsp_end & (out_q != '0);

    always_comb begin
        out_d = out_q;
        case ({issue, done})
            2'b10:   out_d = out_q + OUT_ONE;
            2'b01:   out_d = out_q - OUT_ONE;
            default: out_d = out_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        case (state_q)
            ST_RUN: begin
                if (dpi_wait) begin
                    state_d = (out_q == '0 && !issue) ? ST_HALT : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Completes even if dpi_wait dropped meanwhile; resume goes through HALT.
                if (out_q == '0) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (!dpi_wait) begin
                    state_d = ST_RESUME;
                    tmr_d   = TMR_LOAD;
                end
            end
            ST_RESUME: begin
                if (dpi_wait) begin
                    state_d = ST_HALT;
                end else if (tmr_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    tmr_d = tmr_q - TMR_ONE;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            tmr_q      <= '0;
            out_q      <= '0;
            accel_en_q <= 1'b1;
            halted_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            out_q      <= out_d;
            accel_en_q <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
            halted_q   <= (state_d == ST_HALT);
            if (rsp_end && out_q == '0) begin
                err_q <= 1'b1;
            end
        end
    end

    assign accel_en      = accel_en_q;
    assign halted        = halted_q;
    assign outstanding   = out_q;
    assign err_underflow = err_q;

    vta_sat_counter #(.W(CNT_W)) u_run_cnt (
        .clk   (clock),
        .rst_n (reset),
        .inc   (accel_en_q),
        .clr   (cnt_clear),
        .cnt   (run_cycles)
    );

    vta_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clock),
        .rst_n (reset),
        .inc   (~accel_en_q),
        .clr   (cnt_clear),
        .cnt   (stall_cycles)
    );

endmodule

// File: tb/tb_vta_sim_stall_ctrl.sv
// Bench for vta_sim_stall_ctrl: directed scenarios plus randomized traffic checked against a behavioural model.
module tb_vta_sim_stall_ctrl;

    localparam int MAXO = 8;
    localparam int CW   = 4;
    localparam int RD   = 2;
    localparam int SAT  = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          dpi_wait, req_valid_in, req_ready_out, rsp_valid, rsp_last, cnt_clear;
    logic          req_ready_in, req_valid_out, accel_en, halted, err_underflow;
    logic [3:0]    outstanding;
    logic [CW-1:0] run_cycles, stall_cycles;

    int vectors    = 0;
    int miscompares = 0;
    bit chk_en     = 1'b0;

    vta_sim_stall_ctrl #(.MAX_OUTSTANDING(MAXO), .CNT_W(CW), .RESUME_DLY(RD)) dut (
        .clock         (clock),
        .reset         (reset),
        .dpi_wait      (dpi_wait),
        .req_valid_in  (req_valid_in),
        .req_ready_in  (req_ready_in),
        .req_valid_out (req_valid_out),
        .req_ready_out (req_ready_out),
        .rsp_valid     (rsp_valid),
        .rsp_last      (rsp_last),
        .accel_en      (accel_en),
        .halted        (halted),
        .outstanding   (outstanding),
        .cnt_clear     (cnt_clear),
        .run_cycles    (run_cycles),
        .stall_cycles  (stall_cycles),
        .err_underflow (err_underflow)
    );

    always #5 clock = ~clock;

    // Behavioural model: "running" means none of draining / halted / resume countdown is active.
    int m_out, m_res, m_run, m_stall;
    bit m_drain, m_halt, m_err;

    function automatic bit m_running();
        return !m_drain && !m_halt && (m_res == 0);
    endfunction

    task automatic m_reset();
        m_out = 0; m_res = 0; m_run = 0; m_stall = 0;
        m_drain = 0; m_halt = 0; m_err = 0;
    endtask

    always @(negedge reset) m_reset();

    always @(posedge clock) begin
        bit run_now, blk, iss, dn, acc;
        if (reset) begin
            run_now = m_running();
            blk     = !run_now || (m_out == MAXO);
            iss     = req_valid_in && req_ready_out && !blk;
            dn      = rsp_valid && rsp_last && (m_out > 0);
            acc     = run_now || m_drain;
            if (rsp_valid && rsp_last && m_out == 0) m_err = 1;
            if (cnt_clear) begin
                m_run = 0; m_stall = 0;
            end else if (acc) begin
                m_run = (m_run < SAT) ? m_run + 1 : SAT;
            end else begin
                m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
            end
            if (run_now) begin
                if (dpi_wait) begin
                    if (m_out == 0 && !iss) m_halt = 1;
                    else m_drain = 1;
                end
            end else if (m_drain) begin
                if (m_out == 0) begin m_drain = 0; m_halt = 1; end
            end else if (m_halt) begin
                if (!dpi_wait) begin m_halt = 0; m_res = RD; end
            end else begin
                if (dpi_wait) begin m_res = 0; m_halt = 1; end
                else m_res = m_res - 1;
            end
            m_out = m_out + int'(iss) - int'(dn);
        end
    end

    // Cycle-by-cycle monitor against the model.
    always @(negedge clock) begin
        bit e_acc, e_blk;
        if (chk_en) begin
            e_acc = m_running() || m_drain;
            e_blk = !m_running() || (m_out == MAXO);
            vectors++; if (accel_en !== e_acc) begin miscompares++; $display("FAIL mon_accel_en t=%0t got %b exp %b", $time, accel_en, e_acc); end
            vectors++; if (halted !== m_halt) begin miscompares++; $display("FAIL mon_halted t=%0t got %b exp %b", $time, halted, m_halt); end
            vectors++; if (int'(outstanding) !== m_out) begin miscompares++; $display("FAIL mon_outstanding t=%0t got %0d exp %0d", $time, outstanding, m_out); end
            vectors++; if (req_valid_out !== (req_valid_in && !e_blk)) begin miscompares++; $display("FAIL mon_req_valid_out t=%0t got %b exp %b", $time, req_valid_out, req_valid_in && !e_blk); end
            vectors++; if (req_ready_in !== (req_ready_out && !e_blk)) begin miscompares++; $display("FAIL mon_req_ready_in t=%0t got %b exp %b", $time, req_ready_in, req_ready_out && !e_blk); end
            vectors++; if (int'(run_cycles) !== m_run) begin miscompares++; $display("FAIL mon_run_cycles t=%0t got %0d exp %0d", $time, run_cycles, m_run); end
            vectors++; if (int'(stall_cycles) !== m_stall) begin miscompares++; $display("FAIL mon_stall_cycles t=%0t got %0d exp %0d", $time, stall_cycles, m_stall); end
            vectors++; if (err_underflow !== m_err) begin miscompares++; $display("FAIL mon_err_underflow t=%0t got %b exp %b", $time, err_underflow, m_err); end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            @(negedge clock);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; dpi_wait = 0; req_valid_in = 0; req_ready_out = 0;
        rsp_valid = 0; rsp_last = 0; cnt_clear = 0;
        m_reset();
        #12;
        vectors++; if (accel_en !== 1'b1) begin miscompares++; $display("FAIL reset_accel_en got %b exp 1", accel_en); end
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted got %b exp 0", halted); end
        vectors++; if (outstanding !== 4'd0) begin miscompares++; $display("FAIL reset_outstanding got %0d exp 0", outstanding); end
        vectors++; if (run_cycles !== '0 || stall_cycles !== '0) begin miscompares++; $display("FAIL reset_counters got %0d/%0d exp 0/0", run_cycles, stall_cycles); end
        vectors++; if (err_underflow !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b exp 0", err_underflow); end
        @(negedge clock); #1;
        reset  = 1'b1;
        chk_en = 1'b1;
    endtask

    task automatic test_idle_freeze();
        dpi_wait = 1; step();
        vectors++; if (accel_en !== 1'b0 || halted !== 1'b1) begin miscompares++; $display("FAIL freeze_enter got en=%b h=%b exp en=0 h=1", accel_en, halted); end
        step(9);
        dpi_wait = 0;
        for (int i = 1; i <= RD + 1; i++) begin
            step();
            vectors++; if (accel_en !== (i == RD + 1)) begin miscompares++; $display("FAIL freeze_resume edge=%0d got %b exp %b", i, accel_en, i == RD + 1); end
        end
    endtask

    task automatic test_drain();
        req_valid_in = 1; req_ready_out = 1; step(3);
        req_valid_in = 0;
        vectors++; if (outstanding !== 4'd3) begin miscompares++; $display("FAIL drain_issue got %0d exp 3", outstanding); end
        dpi_wait = 1; step();
        req_valid_in = 1; #1;
        vectors++; if (accel_en !== 1'b1 || halted !== 1'b0 || req_ready_in !== 1'b0 || req_valid_out !== 1'b0)
            begin miscompares++; $display("FAIL drain_state got en=%b h=%b rdy=%b vld=%b exp 1 0 0 0", accel_en, halted, req_ready_in, req_valid_out); end
        req_valid_in = 0;
        rsp_valid = 1; rsp_last = 1; step(3);
        rsp_valid = 0; rsp_last = 0;
        vectors++; if (outstanding !== 4'd0 || halted !== 1'b0) begin miscompares++; $display("FAIL drain_empty got out=%0d h=%b exp 0 0", outstanding, halted); end
        step();
        vectors++; if (halted !== 1'b1 || accel_en !== 1'b0) begin miscompares++; $display("FAIL drain_halt got h=%b en=%b exp 1 0", halted, accel_en); end
        dpi_wait = 0; step(RD + 1);
    endtask

    task automatic test_full();
        req_valid_in = 1; req_ready_out = 1; step(MAXO);
        #1;
        vectors++; if (outstanding !== 4'd8 || req_valid_out !== 1'b0 || req_ready_in !== 1'b0)
            begin miscompares++; $display("FAIL full_block got out=%0d vld=%b rdy=%b exp 8 0 0", outstanding, req_valid_out, req_ready_in); end
        req_valid_in = 0; rsp_valid = 1; rsp_last = 1; step(3);
        req_valid_in = 1; step();
        vectors++; if (outstanding !== 4'd5) begin miscompares++; $display("FAIL full_issue_done got %0d exp 5", outstanding); end
        req_valid_in = 0; step(5);
        rsp_valid = 0; rsp_last = 0;
        vectors++; if (outstanding !== 4'd0) begin miscompares++; $display("FAIL full_empty got %0d exp 0", outstanding); end
    endtask

    task automatic test_resume_abort();
        dpi_wait = 1; step();
        dpi_wait = 0; step();
        vectors++; if (accel_en !== 1'b0 || halted !== 1'b0) begin miscompares++; $display("FAIL abort_resume got en=%b h=%b exp 0 0", accel_en, halted); end
        dpi_wait = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++; if (accel_en !== 1'b0 || halted !== 1'b1) begin miscompares++; $display("FAIL abort_halt cyc=%0d got en=%b h=%b exp 0 1", i, accel_en, halted); end
        end
        dpi_wait = 0; step(RD + 1);
        vectors++; if (accel_en !== 1'b1) begin miscompares++; $display("FAIL abort_run got %b exp 1", accel_en); end
    endtask

    task automatic test_counters();
        cnt_clear = 1; step();
        vectors++; if (run_cycles !== '0 || stall_cycles !== '0) begin miscompares++; $display("FAIL cnt_clear got %0d/%0d exp 0/0", run_cycles, stall_cycles); end
        cnt_clear = 0; step(20);
        vectors++; if (int'(run_cycles) !== SAT) begin miscompares++; $display("FAIL cnt_saturate got %0d exp %0d", run_cycles, SAT); end
        cnt_clear = 1; step();
        cnt_clear = 0;
        vectors++; if (run_cycles !== '0) begin miscompares++; $display("FAIL cnt_clear_inc got %0d exp 0", run_cycles); end
    endtask

    task automatic test_underflow();
        rsp_valid = 1; rsp_last = 1; step();
        rsp_valid = 0; rsp_last = 0;
        vectors++; if (err_underflow !== 1'b1) begin miscompares++; $display("FAIL underflow_set got %b exp 1", err_underflow); end
        step(5);
        vectors++; if (err_underflow !== 1'b1 || outstanding !== 4'd0) begin miscompares++; $display("FAIL underflow_sticky got err=%b out=%0d exp 1 0", err_underflow, outstanding); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 24) == 0) dpi_wait = ~dpi_wait;
            req_valid_in  = ($urandom_range(0, 1) == 1);
            req_ready_out = ($urandom_range(0, 9) < 7);
            rsp_valid     = ($urandom_range(0, 9) < 4);
            rsp_last      = ($urandom_range(0, 9) < 6);
            cnt_clear     = ($urandom_range(0, 29) == 0);
            step();
        end
        dpi_wait = 0; req_valid_in = 0; cnt_clear = 0;
        rsp_valid = 1; rsp_last = 1; step(20);
        rsp_valid = 0; rsp_last = 0;
        vectors++; if (accel_en !== 1'b1 || halted !== 1'b0 || outstanding !== 4'd0) begin miscompares++; $display("FAIL random_settle got en=%b h=%b out=%0d exp 1 0 0", accel_en, halted, outstanding); end
    endtask

    task automatic test_reset_mid();
        req_valid_in = 1; req_ready_out = 1; step(4);
        req_valid_in = 0; dpi_wait = 1; step();
        vectors++; if (outstanding !== 4'd4 || accel_en !== 1'b1 || halted !== 1'b0 || err_underflow !== 1'b1)
            begin miscompares++; $display("FAIL rstmid_drain got out=%0d en=%b h=%b err=%b exp 4 1 0 1", outstanding, accel_en, halted, err_underflow); end
        #2 reset = 1'b0;
        #1;
        vectors++; if (outstanding !== 4'd0 || accel_en !== 1'b1 || halted !== 1'b0 || err_underflow !== 1'b0 || req_ready_in !== 1'b1)
            begin miscompares++; $display("FAIL rstmid_async got out=%0d en=%b h=%b err=%b rdy=%b exp 0 1 0 0 1", outstanding, accel_en, halted, err_underflow, req_ready_in); end
        vectors++; if (run_cycles !== '0 || stall_cycles !== '0) begin miscompares++; $display("FAIL rstmid_counters got %0d/%0d exp 0/0", run_cycles, stall_cycles); end
        dpi_wait = 0;
        @(negedge clock); #1;
        reset = 1'b1;
        step(2);
        vectors++; if (accel_en !== 1'b1 || int'(run_cycles) !== 2) begin miscompares++; $display("FAIL rstmid_run got en=%b run=%0d exp 1 2", accel_en, run_cycles); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_idle_freeze();
        test_drain();
        test_full();
        test_resume_abort();
        test_counters();
        test_underflow();
        test_random();
        test_underflow();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vta_sim_stall_ctrl.md
Name: vta_sim_stall_ctrl

Overview:
- Sits directly downstream of the DPI wait stage in the tsim shell; consumes its registered dpi_wait.
- Turns a wait request into a clean accelerator freeze:
  - blocks new memory requests;
  - drains outstanding read bursts;
  - deasserts the accelerator clock enable;
  - after dpi_wait drops, resumes following a fixed guard delay.
- Also maintains saturating run/stall cycle counters for host profiling.

Parameters:
- MAX_OUTSTANDING, 8, maximum in-flight memory bursts; power of two, >=2.
- CNT_W, 32, width of the run and stall cycle counters.
- RESUME_DLY, 2, guard cycles spent in RESUME before returning to RUN; >=1.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- dpi_wait  in  1  wait request from the DPI stage; level-sensitive.
- req_valid_in  in  1  accelerator memory request valid.
- req_ready_in  out  1  ready back to the accelerator.
- req_valid_out  out  1  request valid to the memory model.
- req_ready_out  in  1  ready from the memory model.
- rsp_valid  in  1  response beat valid (observed only, not backpressured).
- rsp_last  in  1  last beat of a burst.
- accel_en  out  1  accelerator clock enable.
- halted  out  1  high while in HALT.
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  current in-flight burst count.
- cnt_clear  in  1  synchronous clear of both counters.
- run_cycles  out  CNT_W  cycles with accel_en=1.
- stall_cycles  out  CNT_W  cycles with accel_en=0.
- err_underflow  out  1  sticky flag: rsp_last seen while outstanding==0.

Behaviour:
- Reset (reset=0, async):
  - state=RUN; accel_en=1; halted=0.
  - outstanding, both counters, resume timer and err_underflow all 0.
- block = (state!=RUN) | (outstanding==MAX_OUTSTANDING).
- Request path is combinational:
  - req_valid_out = req_valid_in & ~block.
  - req_ready_in = req_ready_out & ~block.
- issue = req_valid_out & req_ready_out. done = rsp_valid & rsp_last & (outstanding!=0).
- outstanding update per cycle: +1 on issue, -1 on done; both in the same cycle = unchanged.
- err_underflow sets when rsp_valid & rsp_last & outstanding==0. Cleared only by reset. The counter does not go negative.
- FSM, registered, one transition per clock:
  - RUN: accel_en=1.
    - dpi_wait=1 and outstanding==0 and no issue this cycle -> HALT.
    - dpi_wait=1 otherwise -> DRAIN.
  - DRAIN: accel_en=1 so responses can complete; no new issues (block=1).
    - outstanding==0 -> HALT, also if dpi_wait has already dropped. A freeze always completes once started.
  - HALT: accel_en=0; halted=1.
    - dpi_wait=0 -> RESUME, timer loads RESUME_DLY-1.
  - RESUME: accel_en=0; block=1.
    - dpi_wait=1 -> HALT (abort resume).
    - Otherwise timer decrements; at 0 -> RUN.
- accel_en and halted are registered outputs, decoded from the next-state.
- Latency:
  - dpi_wait rising with idle memory -> accel_en low on the next clock edge.
  - dpi_wait falling in HALT -> accel_en high exactly RESUME_DLY+1 edges later.
- Counters:
  - Each cycle, run_cycles increments if accel_en=1, otherwise stall_cycles increments.
  - Both saturate at 2^CNT_W-1.
  - cnt_clear has priority over increment; the cleared value is 0 for that cycle.
- A mid-operation reset returns to RUN with outstanding=0. In-flight bursts are discarded; the memory model is reset by the same signal.

Decomposition:
- Package vta_sim_pkg holds:
  - the state enum (RUN, DRAIN, HALT, RESUME), 2 bits;
  - the OUTST_W computation.
- One sub-module, vta_sat_counter (params W; inputs inc, clr), instanced twice for run_cycles and stall_cycles.
- The outstanding tracker and FSM stay in the top module.

Test Plan:
- Idle freeze: outstanding=0, dpi_wait high at cycle 10 -> accel_en=0 and halted=1 from cycle 11. dpi_wait low at cycle 20 -> accel_en=1 at cycle 23 (RESUME_DLY=2).
- Drain: issue 3 requests, assert dpi_wait -> state DRAIN, req_ready_in=0, accel_en=1. After 3 rsp_last beats -> outstanding=0, then HALT on the next edge.
- Full: 8 accepted requests, no responses -> req_valid_out=0 and req_ready_in=0. Issue + rsp_last in the same cycle at count 5 -> count stays 5.
- Resume abort: in RESUME, reassert dpi_wait at timer=1 -> HALT, accel_en stays 0 with no 1-cycle glitch.
- Counters: CNT_W=4, run 20 cycles -> run_cycles=15 (saturated). cnt_clear together with inc -> 0.
- Errors/reset: rsp_last with outstanding=0 -> err_underflow=1 and persists. Async reset while in DRAIN with outstanding=4 -> state RUN, outstanding=0, err_underflow=0, all without waiting for a clock edge.
